// File: rtl/kernel_arb_pkg.sv
// Shared state encoding and window sizing for kernel_arbiter.
// Optional watchdog is selected with the KERNEL_ARB_TIMEOUT_EN macro.
package kernel_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int KA_SIZE = 3;
    localparam int WIN_W   = KA_SIZE * KA_SIZE * 8;

    function automatic int win_bits(input int size);
        return size * size * 8;
    endfunction

endpackage

// File: rtl/kernel_arbiter_rr_pick.sv
// Two-way round-robin choice: with both requests active, the one not served last wins.
module rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win,
    output logic       valid
);

    always_comb begin
        win = req;
        if (req == 2'b11) begin
            win = last ? 2'b01 : 2'b10;
        end
    end

    assign valid = |req;

endmodule

// File: rtl/kernel_arbiter.sv
// Two-requester arbiter in front of a convolution engine: grant, clear, run, respond.
// Build with KERNEL_ARB_TIMEOUT_EN defined to add the CLEAR/RUN watchdog.
module kernel_arbiter
    import kernel_arb_pkg::*;
#(
    parameter logic [3:0] SIZE           = 4'd3,
    parameter int         TIMEOUT_CYCLES = 64,
    localparam int        W              = win_bits(int'(SIZE))
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [1:0]   req,
    input  logic [W-1:0] win0,
    input  logic [W-1:0] win1,
    input  logic [W-1:0] ker0,
    input  logic [W-1:0] ker1,
    output logic [1:0]   gnt,
    output logic [1:0]   res_valid,
    input  logic [1:0]   res_ready,
    output logic [7:0]   res_data,
    output logic         res_err,
    output logic         busy,
    output logic [W-1:0] eng_matrix,
    output logic [W-1:0] eng_kernel,
    output logic         eng_start,
    output logic         eng_clear,
    input  logic         eng_done,
    input  logic         eng_clear_flag,
    input  logic [7:0]   eng_result,
    output state_t       fsm_state
);

    state_t     state;
    state_t     state_next;
    logic       last;
    logic [1:0] pick_win;
    logic       pick_valid;
    logic       timeout;
    logic       take_grant;
    logic       take_result;
    logic       take_timeout;
    logic       release_txn;

    rr_pick u_rr_pick (
        .req   (req),
        .last  (last),
        .win   (pick_win),
        .valid (pick_valid)
    );

    // Handshake: res_valid[g] stays high with res_data stable until res_ready[g]
    // is sampled high; ready on the other bit or outside RESP has no effect.
    assign take_grant   = (state == IDLE) && pick_valid;
    assign take_result  = (state == RUN) && eng_done;
    assign take_timeout = timeout && !take_result;
    assign release_txn  = (state == RESP) && ((res_ready & gnt) != 2'b00);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (pick_valid) state_next = CLEAR;
            CLEAR: begin
                if (timeout) begin
                    state_next = RESP;
                end else if (eng_clear_flag) begin
                    state_next = RUN;
                end
            end
            RUN:   if (eng_done || timeout) state_next = RESP;
            RESP:  if (release_txn) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        eng_clear = (state == CLEAR);
        eng_start = (state == RUN);
        res_valid = (state == RESP) ? gnt : 2'b00;
        fsm_state = state;
    end

    // last == 1 means requester 1 was served last, so requester 0 wins a tie.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            gnt        <= 2'b00;
            last       <= 1'b1;
            res_data   <= 8'h00;
            eng_matrix <= '0;
            eng_kernel <= '0;
        end else begin
            if (take_grant) begin
                gnt        <= pick_win;
                eng_matrix <= pick_win[1] ? win1 : win0;
                eng_kernel <= pick_win[1] ? ker1 : ker0;
            end
            if (take_result) begin
                res_data <= eng_result;
            end else if (take_timeout) begin
                res_data <= 8'h00;
            end
            if (release_txn) begin
                gnt  <= 2'b00;
                last <= gnt[1];
            end
        end
    end

`ifdef KERNEL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          err_q;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (take_grant) begin
                cnt <= '0;
            end else if (state == CLEAR || state == RUN) begin
                cnt <= cnt + CW'(1);
            end
            if (take_timeout) begin
                err_q <= 1'b1;
            end else if (release_txn) begin
                err_q <= 1'b0;
            end
        end
    end

    assign timeout = (state == CLEAR || state == RUN) && (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign res_err = err_q;
`else
    assign timeout = 1'b0;
    assign res_err = 1'b0;
`endif

endmodule

// File: doc/kernel_arbiter.md
KERNEL_ARBITER -- requirements
Module: kernel_arbiter

Interface
REQ-001 SHALL have parameter SIZE, default 4'd3, meaning the kernel/window edge length in cells.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the watchdog limit in cycles (used only under REQ-031).
REQ-003 SHALL have clk, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have n_rst, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have req, input, 2, per-requester level request; bit i belongs to requester i.
REQ-006 SHALL have win0/win1, input, SIZE*SIZE*8 each, per-requester pixel window.
REQ-007 SHALL have ker0/ker1, input, SIZE*SIZE*8 each, per-requester kernel.
REQ-008 SHALL have gnt, output, 2, one-hot grant held for the whole transaction.
REQ-009 SHALL have res_valid, output, 2, per-requester result valid.
REQ-010 SHALL have res_ready, input, 2, per-requester result accept.
REQ-011 SHALL have res_data, output, 8, shared result byte.
REQ-012 SHALL have res_err, output, 1, qualifies res_data as a timeout result.
REQ-013 SHALL have busy, output, 1, high in any state other than IDLE.
REQ-014 SHALL have eng_matrix/eng_kernel, output, SIZE*SIZE*8 each, registered operands sent to the convolution engine.
REQ-015 SHALL have eng_start and eng_clear, output, 1 each, engine controls.
REQ-016 SHALL have eng_done, eng_clear_flag and eng_result, input, 1/1/8, engine status and result.

Function
REQ-017 SHALL implement FSM IDLE -> CLEAR -> RUN -> RESP -> IDLE.
- IDLE: if any req bit is set, pick a winner, register its win/ker into eng_matrix/eng_kernel, set gnt, and go to CLEAR.
- The IDLE decision takes one cycle; gnt is visible on the next edge.
REQ-018 SHALL pick the winner round-robin: when both requesters are active, the one not served last wins; when one is active, it wins; after reset requester 0 has priority.
REQ-019 CLEAR SHALL hold eng_clear=1 until eng_clear_flag=1 is sampled, then go to RUN with eng_clear=0.
REQ-020 RUN SHALL hold eng_start=1 continuously until eng_done=1 is sampled; on that edge it captures eng_result into res_data, drops eng_start and goes to RESP.
REQ-021 RESP SHALL hold res_valid[g]=1 (g = granted index) with res_data stable until res_ready[g]=1 is sampled.
- On that edge: clear res_valid and gnt, update the last-served pointer, return to IDLE.
REQ-022 Back-to-back: a pending request SHALL be granted in the IDLE cycle following RESP, so there is exactly one IDLE cycle between transactions.
REQ-023 Operand changes, or deassertion of req, after the grant SHALL be ignored; the transaction completes on the latched operands.
REQ-024 res_ready on a non-granted bit, or outside RESP, SHALL be ignored.
REQ-025 eng_done outside RUN and eng_clear_flag outside CLEAR SHALL be ignored.
REQ-026 At most one gnt bit and at most one res_valid bit SHALL be high at any time.
REQ-027 Minimum latency from req to res_valid SHALL be 4 cycles, given eng_clear_flag and eng_done each answer in one cycle.

Reset
REQ-028 With n_rst=0 at a clock edge, the block SHALL enter IDLE and drive these outputs to 0: gnt, res_valid, res_data, res_err, busy, eng_start, eng_clear, eng_matrix, eng_kernel.
- The last-served pointer is set so that requester 0 wins first.
REQ-029 A reset mid-transaction SHALL abandon the transaction with no res_valid; eng_start is low in the cycle after the reset edge.

Configuration
REQ-030 Macro KERNEL_ARB_TIMEOUT_EN SHALL select the watchdog.
REQ-031 With KERNEL_ARB_TIMEOUT_EN defined:
- A counter is cleared on entry to CLEAR and counts in CLEAR and RUN.
- On reaching TIMEOUT_CYCLES, the block drops eng_start/eng_clear, sets res_data=0 and res_err=1, and goes to RESP.
- res_err clears with res_valid.
REQ-032 Without KERNEL_ARB_TIMEOUT_EN, no counter SHALL exist, res_err SHALL be tied 0, and CLEAR/RUN SHALL wait indefinitely.

Structure
REQ-033 Package kernel_arb_pkg SHALL hold the state enum (IDLE, CLEAR, RUN, RESP) and the localparam for the window width, SIZE*SIZE*8.
REQ-034 Sub-module rr_pick SHALL implement the 2-way round-robin choice (inputs req and last; outputs one-hot win and valid); it is combinational and instantiated once.

Verification
REQ-035 Scenario 1: req=01, clear_flag after 1 cycle, done after 9 cycles with eng_result=8'h5A, res_ready=01 held -> gnt=01, res_valid=01, res_data=8'h5A, then back to IDLE.
REQ-036 Scenario 2: req=11 held for three transactions from reset -> grants in order 01, 10, 01, with exactly one IDLE cycle between transactions.
REQ-037 Scenario 3: win0 changed to all 8'hFF during RUN -> eng_matrix keeps the values latched at grant.
REQ-038 Scenario 4: res_ready withheld for 20 cycles in RESP -> res_valid and res_data stable for those 20 cycles, with no new grant.
REQ-039 Scenario 5: n_rst=0 asserted mid-RUN -> next cycle eng_start=0, gnt=00, busy=0, no res_valid.
REQ-040 Scenario 6 (KERNEL_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): eng_done never asserted -> res_valid plus res_err=1 with res_data=0 in RESP, reached 16 cycles after entering CLEAR.
